// File: rtl/ctrl_seq_pkg.sv
// Shared opcodes, states and length tables
// for the control-path step sequencer.
package ctrl_seq_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_RUN   = 3'd1,
    S_INT   = 3'd2,
    S_STOP  = 3'd3,
    S_SSTEP = 3'd4,
    S_HALT  = 3'd5
  } seq_state_e;

  function automatic logic [3:0] instr_len(
    input logic [4:0] opc
  );
    logic [3:0] len;
    unique case (1'b1)
      opc inside {OP_LD, OP_ST}:
        len = 4'd8;
      opc inside {OP_LDI, [OP_ADD:OP_ORI]}:
        len = 4'd6;
      opc inside {OP_MUL, OP_DIV, OP_BR}:
        len = 4'd7;
      opc inside {OP_NEG, OP_NOT, OP_JAL}:
        len = 4'd5;
      opc inside {OP_JR, [OP_IN:OP_MFLO]}:
        len = 4'd4;
      default:
        len = 4'd3;
    endcase
    return len;
  endfunction

  function automatic logic is_mem_step(
    input logic [4:0] opc,
    input logic [2:0] step
  );
    return (step == 3'd1)
      || (opc == OP_LD && step == 3'd6)
      || (opc == OP_ST && step == 3'd7);
  endfunction

  function automatic logic is_illegal(
    input logic [4:0] opc
  );
    return opc > OP_HALT;
  endfunction

endpackage

// File: rtl/ctrl_step_sequencer_ring.sv
// One-hot step ring: clear, load T0,
// advance one step, or hold.
module step_ring #(
  parameter int MAX_STEPS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 zero,
  input  logic                 load,
  input  logic                 adv,
  output logic [MAX_STEPS-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zero) begin
      q <= '0;
    end else if (load) begin
      q <= {{(MAX_STEPS-1){1'b0}}, 1'b1};
    end else if (adv) begin
      q <= {q[MAX_STEPS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Multi-cycle control-path step sequencer
// with wait states, debug and interrupts.
module ctrl_step_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OPC_WIDTH   = 5,
  parameter int MAX_STEPS   = 8,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  mem_ready,
  input  logic                  stop,
  input  logic                  step_mode,
  input  logic                  step_go,
  input  logic                  int_req,
  input  logic                  int_en,
  output logic [MAX_STEPS-1:0]  t_step,
  output logic                  run,
  output logic                  clear,
  output logic                  mem_stall,
  output logic                  instr_done,
  output logic                  int_ack,
  output logic                  int_vec_sel,
  output logic                  illegal_op,
  output logic [2:0]            seq_state
);

  if (MAX_STEPS < 8) begin : g_bad_steps
    $error("MAX_STEPS must be at least 8");
  end

  seq_state_e state, state_nx;
  logic [4:0] opc;
  logic [2:0] idx;
  logic       stalled, boundary;
  logic       ring_zero, ring_load, ring_adv;
  logic       ill_t2;
  logic       unused_ir;

  assign opc = 5'(ir[DATA_WIDTH-1 -: OPC_WIDTH]);
  assign unused_ir = ^ir[DATA_WIDTH-OPC_WIDTH-1:0];

  // Longest instruction is 8 steps, so only
  // the low byte of the ring is ever hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (t_step[i]) idx = 3'(i);
    end
  end

  assign stalled = (state == S_RUN)
    && (MEM_WAIT_EN != 0)
    && is_mem_step(opc, idx)
    && !mem_ready;

  assign boundary = (state == S_RUN)
    && !stalled
    && ({1'b0, idx} == instr_len(opc) - 4'd1);

  assign ill_t2 = (state == S_RUN)
    && (idx == 3'd2)
    && is_illegal(opc);

  assign mem_stall  = stalled;
  assign instr_done = boundary;
  assign seq_state  = state;

  always_comb begin
    state_nx  = state;
    ring_load = 1'b0;
    ring_adv  = 1'b0;
    unique case (state)
      S_RST: begin
        state_nx  = S_RUN;
        ring_load = 1'b1;
      end
      S_RUN: begin
        if (boundary) begin
          if (opc == OP_HALT)
            state_nx = S_HALT;
          else if (int_req && int_en)
            state_nx = S_INT;
          else if (stop)
            state_nx = S_STOP;
          else if (step_mode)
            state_nx = S_SSTEP;
          else
            ring_load = 1'b1;
        end else if (!stalled) begin
          ring_adv = 1'b1;
        end
      end
      S_INT: begin
        state_nx  = S_RUN;
        ring_load = 1'b1;
      end
      S_STOP: begin
        if (!stop) begin
          state_nx  = S_RUN;
          ring_load = 1'b1;
        end
      end
      S_SSTEP: begin
        if (step_go && !stop) begin
          state_nx  = S_RUN;
          ring_load = 1'b1;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_RST;
      end
    endcase
  end

  assign ring_zero = boundary && !ring_load;

  step_ring #(
    .MAX_STEPS(MAX_STEPS)
  ) u_ring (
    .clk  (clk),
    .reset(reset),
    .zero (ring_zero),
    .load (ring_load),
    .adv  (ring_adv),
    .q    (t_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      run         <= 1'b1;
      clear       <= 1'b1;
      int_ack     <= 1'b0;
      int_vec_sel <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      state       <= state_nx;
      run         <= !(state_nx inside
                       {S_STOP, S_SSTEP, S_HALT});
      clear       <= 1'b0;
      int_ack     <= (state_nx == S_INT);
      int_vec_sel <= (state == S_INT);
      illegal_op  <= illegal_op | ill_t2;
    end
  end

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Bench: per-cycle model compare on two
// sequencers (wait states on/off) plus literals.
module tb_ctrl_step_sequencer;

  localparam int M_RST   = 0;
  localparam int M_RUN   = 1;
  localparam int M_INT   = 2;
  localparam int M_STOP  = 3;
  localparam int M_SSTEP = 4;
  localparam int M_HALT  = 5;

  localparam logic [4:0] C_LD   = 5'b00000;
  localparam logic [4:0] C_ALU  = 5'b00011;
  localparam logic [4:0] C_JR   = 5'b10100;
  localparam logic [4:0] C_NOP  = 5'b11010;
  localparam logic [4:0] C_HALT = 5'b11011;
  localparam logic [4:0] C_BAD  = 5'b11111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        mem_ready, stop, step_mode;
  logic        step_go, int_req, int_en;

  logic [1:0][7:0] ts;
  logic [1:0][2:0] st_unused;
  logic [1:0] run_o, clr_o, stall_o, done_o;
  logic [1:0] ack_o, vec_o, ill_o;

  int errors = 0;
  int checks = 0;

  int m_mode [2];
  int m_step [2];
  bit m_vec  [2];
  bit m_ill  [2];
  bit wait_en [2] = '{1'b1, 1'b0};

  ctrl_step_sequencer #(.MEM_WAIT_EN(1)) dut0 (
    .clk(clk), .reset(reset), .ir(ir),
    .mem_ready(mem_ready), .stop(stop),
    .step_mode(step_mode), .step_go(step_go),
    .int_req(int_req), .int_en(int_en),
    .t_step(ts[0]), .run(run_o[0]),
    .clear(clr_o[0]), .mem_stall(stall_o[0]),
    .instr_done(done_o[0]), .int_ack(ack_o[0]),
    .int_vec_sel(vec_o[0]),
    .illegal_op(ill_o[0]),
    .seq_state(st_unused[0])
  );

  ctrl_step_sequencer #(.MEM_WAIT_EN(0)) dut1 (
    .clk(clk), .reset(reset), .ir(ir),
    .mem_ready(mem_ready), .stop(stop),
    .step_mode(step_mode), .step_go(step_go),
    .int_req(int_req), .int_en(int_en),
    .t_step(ts[1]), .run(run_o[1]),
    .clear(clr_o[1]), .mem_stall(stall_o[1]),
    .instr_done(done_o[1]), .int_ack(ack_o[1]),
    .int_vec_sel(vec_o[1]),
    .illegal_op(ill_o[1]),
    .seq_state(st_unused[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  function automatic int spec_len(input int o);
    if (o == 0 || o == 2) return 8;
    if (o == 1 || (o >= 3 && o <= 14)) return 6;
    if (o == 15 || o == 16 || o == 19) return 7;
    if (o == 17 || o == 18 || o == 21) return 5;
    if (o == 20 || (o >= 22 && o <= 25)) return 4;
    return 3;
  endfunction

  function automatic bit m_stall(input int u);
    int o, s;
    bit mem;
    o = int'(ir[31:27]);
    s = m_step[u];
    mem = (s == 1) || (o == 0 && s == 6)
       || (o == 2 && s == 7);
    return m_mode[u] == M_RUN && wait_en[u]
        && mem && !mem_ready;
  endfunction

  task automatic model_adv(input int u);
    int o, len;
    bit stl;
    o = int'(ir[31:27]);
    len = spec_len(o);
    stl = m_stall(u);
    if (reset) begin
      m_mode[u] = M_RST;
      m_step[u] = 0;
      m_vec[u] = 0;
      m_ill[u] = 0;
      return;
    end
    m_vec[u] = 0;
    case (m_mode[u])
      M_RST: begin
        m_mode[u] = M_RUN;
        m_step[u] = 0;
      end
      M_RUN: begin
        if (m_step[u] == 2 && o > 27) m_ill[u] = 1;
        if (!stl) begin
          if (m_step[u] == len - 1) begin
            if (o == 27) m_mode[u] = M_HALT;
            else if (int_req && int_en)
              m_mode[u] = M_INT;
            else if (stop) m_mode[u] = M_STOP;
            else if (step_mode)
              m_mode[u] = M_SSTEP;
            else m_step[u] = 0;
          end else begin
            m_step[u] = m_step[u] + 1;
          end
        end
      end
      M_INT: begin
        m_mode[u] = M_RUN;
        m_step[u] = 0;
        m_vec[u] = 1;
      end
      M_STOP: begin
        if (!stop) begin
          m_mode[u] = M_RUN;
          m_step[u] = 0;
        end
      end
      M_SSTEP: begin
        if (step_go && !stop) begin
          m_mode[u] = M_RUN;
          m_step[u] = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_cmp(input int u);
    logic [7:0] e_ts;
    bit on, stl, done;
    int len;
    on = (m_mode[u] == M_RUN);
    stl = m_stall(u);
    len = spec_len(int'(ir[31:27]));
    done = on && !stl && m_step[u] == len - 1;
    e_ts = 8'h00;
    if (on) e_ts[m_step[u]] = 1'b1;
    chk($sformatf("m%0d t_step", u), ts[u], e_ts);
    chk($sformatf("m%0d run", u), run_o[u],
        !(m_mode[u] inside {M_STOP, M_SSTEP, M_HALT}));
    chk($sformatf("m%0d clear", u), clr_o[u],
        m_mode[u] == M_RST);
    chk($sformatf("m%0d stall", u), stall_o[u], stl);
    chk($sformatf("m%0d done", u), done_o[u], done);
    chk($sformatf("m%0d ack", u), ack_o[u],
        m_mode[u] == M_INT);
    chk($sformatf("m%0d vec", u), vec_o[u], m_vec[u]);
    chk($sformatf("m%0d ill", u), ill_o[u], m_ill[u]);
  endtask

  initial begin
    m_mode = '{M_RST, M_RST};
    m_step = '{0, 0};
    m_vec = '{0, 0};
    m_ill = '{0, 0};
    forever begin
      @(posedge clk);
      for (int u = 0; u < 2; u++) model_adv(u);
      #1;
      for (int u = 0; u < 2; u++) model_cmp(u);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] op);
    @(negedge clk);
    reset = 1'b1;
    ir = {op, 27'd0};
    #1;
    chk("rst t_step", ts[0], 0);
    chk("rst run", run_o[0], 1);
    chk("rst clear", clr_o[0], 1);
    chk("rst ill", ill_o[0], 0);
    chk("rst ack", ack_o[0], 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst hold clear", clr_o[0], 1);
  endtask

  logic [7:0] exp1 [7] = '{8'h01, 8'h02, 8'h04,
                           8'h08, 8'h10, 8'h20, 8'h01};
  logic [7:0] exp2 [7] = '{8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] v;

  initial begin
    reset = 1'b1;
    ir = {C_ALU, 27'd0};
    mem_ready = 1'b1;
    stop = 1'b0;
    step_mode = 1'b0;
    step_go = 1'b0;
    int_req = 1'b0;
    int_en = 1'b0;

    // ALU instruction: six steps then T0
    do_reset(C_ALU);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1 step", ts[0], exp1[i]);
      chk("t1 done", done_o[0], i == 5);
    end
    chk("t1 clear low", clr_o[0], 0);

    // ld with three wait cycles at T1
    ir = {C_LD, 27'd0};
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("t2 hold", ts[0], 8'h02);
      chk("t2 stall", stall_o[0], i < 3);
      v = 8'h02 << i;
      chk("t2 nowait step", ts[1], v);
      chk("t2 nowait stall", stall_o[1], 0);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2 step", ts[0], exp2[i]);
      chk("t2 done", done_o[0], i == 5);
    end

    // halt stays halted until reset
    do_reset(C_HALT);
    for (int i = 0; i < 3; i++) begin
      tick();
      v = 8'h01 << i;
      chk("t3 step", ts[0], v);
      chk("t3 done", done_o[0], i == 2);
    end
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      stop = (i == 5);
      step_go = (i == 10);
      #1;
      chk("t3 halt step", ts[0], 0);
      chk("t3 halt run", run_o[0], 0);
    end

    // interrupt taken at jr boundary
    do_reset(C_JR);
    tick();
    chk("t4 T0", ts[0], 8'h01);
    tick();
    chk("t4 T1", ts[0], 8'h02);
    @(negedge clk);
    int_req = 1'b1;
    int_en = 1'b1;
    #1;
    chk("t4 T2", ts[0], 8'h04);
    tick();
    chk("t4 T3", ts[0], 8'h08);
    chk("t4 done", done_o[0], 1);
    chk("t4 no ack yet", ack_o[0], 0);
    @(negedge clk);
    int_req = 1'b0;
    #1;
    chk("t4 ack", ack_o[0], 1);
    chk("t4 ack step", ts[0], 0);
    tick();
    chk("t4 ack gone", ack_o[0], 0);
    chk("t4 vec T0", ts[0], 8'h01);
    chk("t4 vec", vec_o[0], 1);
    @(negedge clk);
    ir = {C_NOP, 27'd0};
    step_mode = 1'b1;
    #1;
    chk("t4 vec gone", vec_o[0], 0);
    tick();
    chk("t5 nop done", done_o[0], 1);
    tick();
    chk("t5 sstep run", run_o[0], 0);
    chk("t5 sstep step", ts[0], 0);

    // single step, go blocked by stop
    tick();
    chk("t5 idle", run_o[0], 0);
    @(negedge clk);
    step_go = 1'b1;
    stop = 1'b1;
    #1;
    @(negedge clk);
    step_go = 1'b0;
    stop = 1'b0;
    #1;
    chk("t5 go ignored", ts[0], 0);
    chk("t5 go ignored run", run_o[0], 0);
    @(negedge clk);
    step_go = 1'b1;
    #1;
    chk("t5 before go", ts[0], 0);
    @(negedge clk);
    step_go = 1'b0;
    #1;
    chk("t5 go T0", ts[0], 8'h01);
    chk("t5 go run", run_o[0], 1);
    tick();
    chk("t5 T1", ts[0], 8'h02);
    tick();
    chk("t5 T2 done", done_o[0], 1);
    tick();
    chk("t5 repause", run_o[0], 0);
    @(negedge clk);
    step_mode = 1'b0;
    step_go = 1'b1;
    #1;
    @(negedge clk);
    step_go = 1'b0;
    stop = 1'b1;
    #1;
    chk("t5 resume", ts[0], 8'h01);
    tick();
    tick();
    chk("t5 stop done", done_o[0], 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 stopped run", run_o[0], 0);
      chk("t5 stopped step", ts[0], 0);
    end
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("t5 still stopped", run_o[0], 0);
    tick();
    chk("t5 restart", ts[0], 8'h01);
    chk("t5 restart run", run_o[0], 1);

    // illegal opcode, sticky until reset
    ir = {C_BAD, 27'd0};
    int_req = 1'b1;
    int_en = 1'b0;
    tick();
    chk("t6 T1 ill", ill_o[0], 0);
    tick();
    chk("t6 done", done_o[0], 1);
    chk("t6 T2 ill", ill_o[0], 0);
    tick();
    chk("t6 ill set", ill_o[0], 1);
    chk("t6 T0", ts[0], 8'h01);
    chk("t6 masked int", ack_o[0], 0);
    ir = {C_ALU, 27'd0};
    int_req = 1'b0;
    int_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6 sticky", ill_o[0], 1);
    end
    chk("t6 alu wrap", ts[0], 8'h01);
    do_reset(C_ALU);
    tick();
    chk("t6 post rst", ts[0], 8'h01);
    chk("t6 post rst ill", ill_o[0], 0);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
